led_irq_ctrl: RTL and testbench
===============================

// Module: led_irq_ctrl
// PURPOSE
// - Downstream of led_cnt: takes its led_int_o / int_cnt_o and turns them into a
//   level interrupt for the PS. Drives the int_clr pulse back into led_cnt.
// - Adds snapshot of the event count, one-deep pending, a lost-event counter
//   and a re-arm holdoff so software is never flooded.
// PARAMETERS
// - CNT_W      32  width of int_cnt_i / cnt_snap_o / irq_cnt_o
// - MISS_W      8  width of the saturating miss counter
// - HOLDOFF_CYC 16 clk100 cycles after clear before the next edge is served (0 allowed)
// PORTS
// - clk100      in   1      single clock, all logic on rising edge
// - rst_n       in   1      asynchronous, active-low reset
// - en_i        in   1      1 = service interrupts; 0 = ignore edges, drop irq
// - led_int_i   in   1      interrupt level from led_cnt (led_int_o)
// - int_cnt_i   in   CNT_W  event count from led_cnt (int_cnt_o)
// - irq_ack_i   in   1      1-cycle software acknowledge
// - miss_clr_i  in   1      1-cycle clear of miss_cnt_o
// - irq_o       out  1      level interrupt to PS
// - int_clr_o   out  1      1-cycle clear pulse to led_cnt (int_clr_i)
// - cnt_snap_o  out  CNT_W  int_cnt_i captured on the served edge
// - irq_cnt_o   out  CNT_W  number of acknowledged interrupts, wraps
// - pend_o      out  1      one edge waiting behind the current one
// - miss_cnt_o  out  MISS_W edges lost while pend_o=1, saturating
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; edge-detect register 0; holdoff counter 0.
// - Edge = led_int_i==1 this cycle and registered led_int_i==0. All outputs registered.
// - FSM states: IDLE, WAIT_ACK, CLEAR, HOLDOFF.
// - IDLE: edge && en_i at cycle N -> N+1: WAIT_ACK, irq_o=1, cnt_snap_o=int_cnt_i@N.
//   Edge with en_i=0 ignored, not counted.
// - WAIT_ACK: irq_o held 1. irq_ack_i at M -> M+1: CLEAR, irq_o=0, int_clr_o=1,
//   irq_cnt_o+1. en_i falls at M -> M+1: CLEAR, irq_o=0, int_clr_o=1, irq_cnt_o unchanged.
// - CLEAR: exactly one cycle. Next: HOLDOFF if HOLDOFF_CYC>0, else the re-arm decision.
// - HOLDOFF: stays HOLDOFF_CYC cycles, then re-arm decision.
// - Re-arm decision: pend_o && en_i -> WAIT_ACK, irq_o=1, cnt_snap_o=int_cnt_i that
//   cycle, pend_o=0. Otherwise -> IDLE, pend_o=0.
// - irq_ack_i outside WAIT_ACK is ignored.
// - Edge while not IDLE with en_i=1: pend_o=0 -> pend_o=1; pend_o=1 -> miss_cnt_o+1,
//   saturating at all-ones.
// - Edge in the same cycle as the CLEAR pulse counts as a busy-state edge (pend/miss).
// - en_i=0 in any state clears pend_o next cycle.
// - miss_clr_i wins over a simultaneous increment: miss_cnt_o=0.
// - Async reset mid-operation drops irq_o and int_clr_o immediately. Pend and miss are lost.
// - Latency: edge -> irq_o = 1 cycle. ack -> int_clr_o = 1 cycle.
//   ack -> earliest re-assert = HOLDOFF_CYC+2 cycles.
// TESTING
// - Basic: en=1, int_cnt_i=0x2A, led_int_i rises @N -> irq_o=1 @N+1, cnt_snap_o=0x2A.
//   Ack @M -> int_clr_o=1 only @M+1, irq_o=0 @M+1, irq_cnt_o=1.
// - Holdoff: HOLDOFF_CYC=16, 2nd edge 5 cycles after ack -> pend_o=1.
//   irq_o re-asserts exactly 18 cycles after ack, pend_o back to 0.
// - Miss saturation: MISS_W=8, 300 edges while WAIT_ACK -> pend_o=1, miss_cnt_o=255.
//   miss_clr_i together with an edge -> miss_cnt_o=0.
// - Disable: en_i=0 during WAIT_ACK -> irq_o=0 next cycle, one int_clr_o pulse,
//   irq_cnt_o unchanged. Edges while en_i=0 in IDLE -> no irq_o, no count.
// - Reset mid-WAIT_ACK with pend_o=1: rst_n low -> irq_o, pend_o, miss_cnt_o=0 at once.
//   After release, the held-high led_int_i produces no edge until it toggles.
// - HOLDOFF_CYC=0 with pend_o=1 -> CLEAR followed directly by WAIT_ACK, irq_o low for 1 cycle.

Source files
------------

// File: rtl/led_irq_ctrl_if.sv
// led_irq_ctrl_if: upstream event inputs and PS-facing interrupt outputs of led_irq_ctrl
interface led_irq_ctrl_if #(
    parameter int CNT_W  = 32,
    parameter int MISS_W = 8
);
    logic              en_i;
    logic              led_int_i;
    logic [CNT_W-1:0]  int_cnt_i;
    logic              irq_ack_i;
    logic              miss_clr_i;
    logic              irq_o;
    logic              int_clr_o;
    logic [CNT_W-1:0]  cnt_snap_o;
    logic [CNT_W-1:0]  irq_cnt_o;
    logic              pend_o;
    logic [MISS_W-1:0] miss_cnt_o;
    modport master (
        output en_i, led_int_i, int_cnt_i, irq_ack_i, miss_clr_i,
        input  irq_o, int_clr_o, cnt_snap_o, irq_cnt_o, pend_o, miss_cnt_o
    );
    modport slave (
        input  en_i, led_int_i, int_cnt_i, irq_ack_i, miss_clr_i,
        output irq_o, int_clr_o, cnt_snap_o, irq_cnt_o, pend_o, miss_cnt_o
    );
endinterface

// File: rtl/led_irq_ctrl.sv
// led_irq_ctrl: turns led_cnt edges into a PS level irq with snapshot, one-deep pending, miss count and re-arm holdoff
module led_irq_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MISS_W      = 8,
    parameter int HOLDOFF_CYC = 16
) (
    input logic            clk100,
    input logic            rst_n,
    led_irq_ctrl_if.slave  bus
);
    localparam int HW = HOLDOFF_CYC > 1 ? $clog2(HOLDOFF_CYC) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF_CYC > 0 ? HOLDOFF_CYC - 1 : 0);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, CLEAR, HOLDOFF} state_t;
    state_t            state, state_n;
    logic              led_q, primed, edge_det, busy_edge, rearm, acked;
    logic              pend_q, pend_base, pend_n, miss_inc, irq_q, clr_q;
    logic [HW-1:0]     hcnt;
    logic [CNT_W-1:0]  snap_q, ack_q;
    logic [MISS_W-1:0] miss_q;
    // primed masks the first cycle after reset so a level already high is not taken as an edge
    assign edge_det  = primed & bus.led_int_i & ~led_q;
    assign busy_edge = edge_det & bus.en_i & (state != IDLE);
    // next state, re-arm decision and pending/miss bookkeeping
    always_comb begin
        state_n = state;
        rearm   = 1'b0;
        acked   = 1'b0;
        case (state)
            IDLE:     state_n = (edge_det & bus.en_i) ? WAIT_ACK : IDLE;
            WAIT_ACK: begin
                state_n = (!bus.en_i || bus.irq_ack_i) ? CLEAR : WAIT_ACK;
                acked   = bus.en_i & bus.irq_ack_i;
            end
            CLEAR:    begin
                state_n = HOLDOFF_CYC > 0 ? HOLDOFF : CLEAR;
                rearm   = HOLDOFF_CYC == 0;
            end
            HOLDOFF:  rearm = hcnt == H_LAST;
        endcase
        if (rearm) state_n = (pend_q & bus.en_i) ? WAIT_ACK : IDLE;
        pend_base = rearm ? 1'b0 : pend_q;
        pend_n    = bus.en_i & (pend_base | busy_edge);
        miss_inc  = busy_edge & pend_base;
    end
    // state register and registered outputs
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            led_q  <= 1'b0;
            primed <= 1'b0;
            hcnt   <= '0;
            irq_q  <= 1'b0;
            clr_q  <= 1'b0;
            snap_q <= '0;
            ack_q  <= '0;
            pend_q <= 1'b0;
            miss_q <= '0;
        end else begin
            state  <= state_n;
            led_q  <= bus.led_int_i;
            primed <= 1'b1;
            hcnt   <= state == HOLDOFF ? hcnt + 1'b1 : '0;
            irq_q  <= state_n == WAIT_ACK;
            clr_q  <= state_n == CLEAR;
            if (state_n == WAIT_ACK && state != WAIT_ACK) snap_q <= bus.int_cnt_i;
            if (acked) ack_q <= ack_q + 1'b1;
            pend_q <= pend_n;
            miss_q <= bus.miss_clr_i ? '0 : (miss_inc && !(&miss_q)) ? miss_q + 1'b1 : miss_q;
        end
    end
    assign bus.irq_o      = irq_q;
    assign bus.int_clr_o  = clr_q;
    assign bus.cnt_snap_o = snap_q;
    assign bus.irq_cnt_o  = ack_q;
    assign bus.pend_o     = pend_q;
    assign bus.miss_cnt_o = miss_q;
endmodule

// File: tb/tb_led_irq_ctrl.sv
// tb_led_irq_ctrl: directed bench for led_irq_ctrl with holdoff 16 and holdoff 0 instances
module tb_led_irq_ctrl;
    logic clk100 = 1'b0;
    logic rst_n  = 1'b0;
    int   total  = 0;
    int   passed = 0;
    always #5 clk100 = ~clk100;
    led_irq_ctrl_if #(.CNT_W(32), .MISS_W(8)) a ();
    led_irq_ctrl_if #(.CNT_W(32), .MISS_W(8)) b ();
    led_irq_ctrl #(.CNT_W(32), .MISS_W(8), .HOLDOFF_CYC(16)) u16 (.clk100(clk100), .rst_n(rst_n), .bus(a));
    led_irq_ctrl #(.CNT_W(32), .MISS_W(8), .HOLDOFF_CYC(0))  u0  (.clk100(clk100), .rst_n(rst_n), .bus(b));
    task automatic tick;
        @(posedge clk100);
        #1;
    endtask
    task automatic test_reset;
        a.en_i = 0; a.led_int_i = 0; a.int_cnt_i = 0; a.irq_ack_i = 0; a.miss_clr_i = 0;
        b.en_i = 0; b.led_int_i = 0; b.int_cnt_i = 0; b.irq_ack_i = 0; b.miss_clr_i = 0;
        #1;
        total++;
        if ({a.irq_o, a.int_clr_o, a.pend_o, a.miss_cnt_o, a.cnt_snap_o, a.irq_cnt_o} !== '0)
            $display("FAIL reset_a: outputs %0h required 0", {a.irq_o, a.int_clr_o, a.pend_o, a.miss_cnt_o, a.cnt_snap_o, a.irq_cnt_o});
        else passed++;
        total++;
        if ({b.irq_o, b.int_clr_o, b.pend_o, b.miss_cnt_o, b.cnt_snap_o, b.irq_cnt_o} !== '0)
            $display("FAIL reset_b: outputs %0h required 0", {b.irq_o, b.int_clr_o, b.pend_o, b.miss_cnt_o, b.cnt_snap_o, b.irq_cnt_o});
        else passed++;
        repeat (2) @(posedge clk100);
        @(negedge clk100) rst_n = 1'b1;
        tick();
    endtask
    task automatic test_ack_idle;
        a.irq_ack_i = 1;
        tick();
        a.irq_ack_i = 0;
        tick();
        total++;
        if (a.irq_cnt_o !== 0 || a.int_clr_o !== 0)
            $display("FAIL ack_idle: irq_cnt %0d int_clr %0b required 0 0", a.irq_cnt_o, a.int_clr_o);
        else passed++;
    endtask
    task automatic test_basic;
        a.en_i = 1; a.int_cnt_i = 32'h2A; a.led_int_i = 1;
        tick();
        total++;
        if (a.irq_o !== 1 || a.cnt_snap_o !== 32'h2A || a.int_clr_o !== 0)
            $display("FAIL basic_irq: irq %0b snap %0h clr %0b required 1 2a 0", a.irq_o, a.cnt_snap_o, a.int_clr_o);
        else passed++;
        a.int_cnt_i = 32'h33;
        tick();
        total++;
        if (a.irq_o !== 1 || a.cnt_snap_o !== 32'h2A)
            $display("FAIL basic_hold: irq %0b snap %0h required 1 2a", a.irq_o, a.cnt_snap_o);
        else passed++;
        a.led_int_i = 0; a.irq_ack_i = 1;
        tick();
        a.irq_ack_i = 0;
        total++;
        if (a.irq_o !== 0 || a.int_clr_o !== 1 || a.irq_cnt_o !== 1)
            $display("FAIL basic_ack: irq %0b clr %0b irq_cnt %0d required 0 1 1", a.irq_o, a.int_clr_o, a.irq_cnt_o);
        else passed++;
        tick();
        total++;
        if (a.int_clr_o !== 0 || a.irq_o !== 0)
            $display("FAIL basic_clr_pulse: clr %0b irq %0b required 0 0", a.int_clr_o, a.irq_o);
        else passed++;
        repeat (20) tick();
        total++;
        if (a.irq_o !== 0 || a.pend_o !== 0)
            $display("FAIL basic_idle: irq %0b pend %0b required 0 0", a.irq_o, a.pend_o);
        else passed++;
    endtask
    task automatic test_holdoff;
        a.led_int_i = 1; a.int_cnt_i = 32'h40;
        tick();
        a.led_int_i = 0;
        tick();
        a.int_cnt_i = 32'h55; a.irq_ack_i = 1;
        tick();
        a.irq_ack_i = 0;
        total++;
        if (a.int_clr_o !== 1)
            $display("FAIL holdoff_clr: clr %0b required 1", a.int_clr_o);
        else passed++;
        for (int c = 1; c <= 18; c++) begin
            total++;
            if (a.irq_o !== (c == 18))
                $display("FAIL holdoff_irq_c%0d: irq %0b required %0b", c, a.irq_o, c == 18);
            else passed++;
            if (c == 6) begin
                total++;
                if (a.pend_o !== 1) $display("FAIL holdoff_pend: pend %0b required 1", a.pend_o);
                else passed++;
            end
            if (c == 5) a.led_int_i = 1;
            if (c < 18) tick();
        end
        total++;
        if (a.pend_o !== 0 || a.cnt_snap_o !== 32'h55 || a.irq_cnt_o !== 2)
            $display("FAIL holdoff_rearm: pend %0b snap %0h irq_cnt %0d required 0 55 2", a.pend_o, a.cnt_snap_o, a.irq_cnt_o);
        else passed++;
    endtask
    task automatic test_miss_sat;
        for (int i = 0; i < 300; i++) begin
            a.led_int_i = 0;
            tick();
            a.led_int_i = 1;
            tick();
        end
        total++;
        if (a.pend_o !== 1 || a.miss_cnt_o !== 8'd255 || a.irq_o !== 1)
            $display("FAIL miss_sat: pend %0b miss %0d irq %0b required 1 255 1", a.pend_o, a.miss_cnt_o, a.irq_o);
        else passed++;
        a.led_int_i = 0;
        tick();
        a.led_int_i = 1; a.miss_clr_i = 1;
        tick();
        a.miss_clr_i = 0;
        total++;
        if (a.miss_cnt_o !== 0 || a.pend_o !== 1)
            $display("FAIL miss_clr: miss %0d pend %0b required 0 1", a.miss_cnt_o, a.pend_o);
        else passed++;
    endtask
    task automatic test_disable;
        a.en_i = 0;
        tick();
        total++;
        if (a.irq_o !== 0 || a.int_clr_o !== 1 || a.irq_cnt_o !== 2 || a.pend_o !== 0)
            $display("FAIL disable_wait: irq %0b clr %0b irq_cnt %0d pend %0b required 0 1 2 0", a.irq_o, a.int_clr_o, a.irq_cnt_o, a.pend_o);
        else passed++;
        tick();
        total++;
        if (a.int_clr_o !== 0)
            $display("FAIL disable_pulse: clr %0b required 0", a.int_clr_o);
        else passed++;
        repeat (20) tick();
        for (int i = 0; i < 3; i++) begin
            a.led_int_i = 0;
            tick();
            a.led_int_i = 1;
            tick();
        end
        total++;
        if (a.irq_o !== 0 || a.pend_o !== 0 || a.miss_cnt_o !== 0 || a.irq_cnt_o !== 2 || a.cnt_snap_o !== 32'h55)
            $display("FAIL disable_idle: irq %0b pend %0b miss %0d irq_cnt %0d snap %0h required 0 0 0 2 55",
                     a.irq_o, a.pend_o, a.miss_cnt_o, a.irq_cnt_o, a.cnt_snap_o);
        else passed++;
    endtask
    task automatic test_reset_mid;
        a.en_i = 1; a.led_int_i = 0;
        tick();
        a.led_int_i = 1; a.int_cnt_i = 32'h77;
        tick();
        for (int i = 0; i < 2; i++) begin
            a.led_int_i = 0;
            tick();
            a.led_int_i = 1;
            tick();
        end
        total++;
        if (a.irq_o !== 1 || a.pend_o !== 1 || a.miss_cnt_o !== 1)
            $display("FAIL reset_mid_setup: irq %0b pend %0b miss %0d required 1 1 1", a.irq_o, a.pend_o, a.miss_cnt_o);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (a.irq_o !== 0 || a.pend_o !== 0 || a.miss_cnt_o !== 0 || a.int_clr_o !== 0 || a.irq_cnt_o !== 0)
            $display("FAIL reset_mid_async: irq %0b pend %0b miss %0d clr %0b irq_cnt %0d required 0 0 0 0 0",
                     a.irq_o, a.pend_o, a.miss_cnt_o, a.int_clr_o, a.irq_cnt_o);
        else passed++;
        @(negedge clk100) rst_n = 1'b1;
        repeat (5) tick();
        total++;
        if (a.irq_o !== 0)
            $display("FAIL reset_held_level: irq %0b required 0", a.irq_o);
        else passed++;
        a.led_int_i = 0;
        tick();
        a.led_int_i = 1;
        tick();
        total++;
        if (a.irq_o !== 1 || a.cnt_snap_o !== 32'h77)
            $display("FAIL reset_toggle: irq %0b snap %0h required 1 77", a.irq_o, a.cnt_snap_o);
        else passed++;
    endtask
    task automatic test_holdoff0;
        b.en_i = 1; b.led_int_i = 1; b.int_cnt_i = 32'h11;
        tick();
        total++;
        if (b.irq_o !== 1 || b.cnt_snap_o !== 32'h11)
            $display("FAIL h0_irq: irq %0b snap %0h required 1 11", b.irq_o, b.cnt_snap_o);
        else passed++;
        b.led_int_i = 0;
        tick();
        b.led_int_i = 1; b.int_cnt_i = 32'h22;
        tick();
        total++;
        if (b.pend_o !== 1)
            $display("FAIL h0_pend: pend %0b required 1", b.pend_o);
        else passed++;
        b.irq_ack_i = 1;
        tick();
        b.irq_ack_i = 0;
        total++;
        if (b.irq_o !== 0 || b.int_clr_o !== 1 || b.irq_cnt_o !== 1)
            $display("FAIL h0_clear: irq %0b clr %0b irq_cnt %0d required 0 1 1", b.irq_o, b.int_clr_o, b.irq_cnt_o);
        else passed++;
        tick();
        total++;
        if (b.irq_o !== 1 || b.int_clr_o !== 0 || b.pend_o !== 0 || b.cnt_snap_o !== 32'h22)
            $display("FAIL h0_rearm: irq %0b clr %0b pend %0b snap %0h required 1 0 0 22", b.irq_o, b.int_clr_o, b.pend_o, b.cnt_snap_o);
        else passed++;
    endtask
    initial begin
        test_reset();
        test_ack_idle();
        test_basic();
        test_holdoff();
        test_miss_sat();
        test_disable();
        test_reset_mid();
        test_holdoff0();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
